// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the multichannel hysteresis debouncer.
package debounce_pkg;

    localparam int DEFAULT_WIDTH            = 4;
    localparam int DEFAULT_SAMPLE_COUNT_MAX = 25000;
    localparam int DEFAULT_PULSE_COUNT_MAX  = 150;
    localparam int DEFAULT_LONG_PRESS_TICKS = 20000;

    // $clog2 that never returns less than 1, so counters are at least one bit wide.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: saturating up/down integrator, hysteresis level, edge pulses.
// Hold counter for long_press exists only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int PULSE_COUNT_MAX  = DEFAULT_PULSE_COUNT_MAX,
    parameter int LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic glitchy_signal,
    output logic debounced_signal,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_press
);

    localparam int              CW      = clog2_min1(PULSE_COUNT_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(PULSE_COUNT_MAX);

    if (PULSE_COUNT_MAX < 1) begin : g_bad_pulse
        $fatal(1, "debounce_channel: PULSE_COUNT_MAX must be >= 1");
    end
    if (LONG_PRESS_TICKS < 1) begin : g_bad_long
        $fatal(1, "debounce_channel: LONG_PRESS_TICKS must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level;
    logic          level_next;

    always_comb begin
        cnt_next = cnt;
        if (tick) begin
            if (glitchy_signal && (cnt != CNT_MAX)) begin
                cnt_next = cnt + CW'(1);
            end else if (!glitchy_signal && (cnt != '0)) begin
                cnt_next = cnt - CW'(1);
            end
        end
    end

    // Level only moves when the integrator lands on a bound; in between it holds.
    always_comb begin
        level_next = level;
        if (cnt_next == CNT_MAX) begin
            level_next = 1'b1;
        end else if (cnt_next == '0) begin
            level_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            level      <= level_next;
            rise_pulse <= level_next & ~level;
            fall_pulse <= ~level_next & level;
        end
    end

    assign debounced_signal = level;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int            HW       = clog2_min1(LONG_PRESS_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_TICKS);

    logic [HW-1:0] hold;

    // Cleared on the same edge the level falls, so long_press drops together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (!level_next) begin
            hold <= '0;
        end else if (tick && level && (hold != HOLD_MAX)) begin
            hold <= hold + HW'(1);
        end
    end

    assign long_press = (hold == HOLD_MAX);
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/multichannel_hysteresis_debouncer.sv
// Shared sample prescaler feeding WIDTH independent hysteresis debouncer channels.
// Define DEBOUNCE_LONG_PRESS_EN to enable per-channel long_press detection.
module multichannel_hysteresis_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH            = DEFAULT_WIDTH,
    parameter int SAMPLE_COUNT_MAX = DEFAULT_SAMPLE_COUNT_MAX,
    parameter int PULSE_COUNT_MAX  = DEFAULT_PULSE_COUNT_MAX,
    parameter int LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] long_press
);

    localparam int            PW      = clog2_min1(SAMPLE_COUNT_MAX);
    localparam logic [PW-1:0] PRE_MAX = PW'(SAMPLE_COUNT_MAX - 1);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "multichannel_hysteresis_debouncer: WIDTH must be >= 1");
    end
    if (SAMPLE_COUNT_MAX < 1) begin : g_bad_sample
        $fatal(1, "multichannel_hysteresis_debouncer: SAMPLE_COUNT_MAX must be >= 1");
    end

    logic [PW-1:0] pre_cnt;
    logic          tick;

    // Tick is registered on the wrap, so the first one lands SAMPLE_COUNT_MAX cycles after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
            tick    <= 1'b0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .PULSE_COUNT_MAX  (PULSE_COUNT_MAX),
            .LONG_PRESS_TICKS (LONG_PRESS_TICKS)
        ) u_ch (
            .clk              (clk),
            .rst_n            (rst_n),
            .tick             (tick),
            .glitchy_signal   (glitchy_signal[i]),
            .debounced_signal (debounced_signal[i]),
            .rise_pulse       (rise_pulse[i]),
            .fall_pulse       (fall_pulse[i]),
            .long_press       (long_press[i])
        );
    end

endmodule
